pwm_duty_sequencer: RTL

//  Upstream duty source for the PWM stage: generates a breathing/fade envelope
//  (rise, hold-high, fall, hold-low) on `duty`. Drives the PWM stage's duty input.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_frame_timer.sv | 51 +++++
 rtl/pwm_duty_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty sequencer slice.
// The optional DUTY_GAMMA_EN build macro is consumed by pwm_duty_sequencer.sv.
package pwm_pkg;

    localparam int DEFAULT_BIT_WIDTH = 8;
    localparam int DEFAULT_HOLD_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HOLD_HI,
        FALL,
        HOLD_LO
    } seq_state_t;

    // A one-frame prescaler still needs a 1-bit register to keep the ports legal.
    function automatic int presc_width(input int step_frames);
        return (step_frames > 1) ? $clog2(step_frames) : 1;
    endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running PWM frame counter (0..max_value) plus a STEP_FRAMES prescaler
// that turns every STEP_FRAMES-th frame_end into a step_tick.
module pwm_frame_timer
    import pwm_pkg::*;
#(
    parameter int bit_width   = DEFAULT_BIT_WIDTH,
    parameter int STEP_FRAMES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 presc_clr,
    input  logic [bit_width-1:0] max_value,
    output logic                 frame_end,
    output logic                 step_tick
);

    localparam int PW = presc_width(STEP_FRAMES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_FRAMES - 1);

    logic [bit_width-1:0] count_q, count_d;
    logic [PW-1:0]        presc_q, presc_d;

    // Using >= rather than == lets a lowered max_value take effect immediately.
    assign frame_end = enable & (count_q >= max_value);
    assign step_tick = frame_end & (presc_q == PRESC_LAST);

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        if (enable) begin
            count_d = frame_end ? '0 : count_q + 1'b1;
            if (presc_clr) begin
                presc_d = '0;
            end else if (frame_end) begin
                presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            presc_q <= '0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Breathing/fade envelope generator (rise, hold-high, fall, hold-low) feeding a PWM duty input.
// Define DUTY_GAMMA_EN to square the level into duty for a perceptual fade.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int bit_width   = DEFAULT_BIT_WIDTH,
    parameter int STEP_FRAMES = 1,
    parameter int HOLD_W      = DEFAULT_HOLD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [bit_width-1:0] max_value,
    input  logic [bit_width-1:0] level_min,
    input  logic [bit_width-1:0] level_max,
    input  logic [bit_width-1:0] step,
    input  logic [HOLD_W-1:0]    hold_frames,
    output logic [bit_width-1:0] duty,
    output logic                 frame_end,
    output logic                 busy,
    output logic                 cycle_done
);

    seq_state_t           state_q;
    logic [bit_width-1:0] level_q;
    logic [bit_width-1:0] duty_q;
    logic [HOLD_W-1:0]    hold_q;

    logic                 step_tick;
    logic                 start_ok;
    logic                 hold_done;
    logic [bit_width-1:0] step_eff;
    logic [bit_width:0]   rise_sum;
    logic [bit_width-1:0] rise_level;
    logic [bit_width-1:0] fall_gap;
    logic [bit_width-1:0] fall_level;
    logic [bit_width-1:0] duty_next;

    pwm_frame_timer #(
        .bit_width  (bit_width),
        .STEP_FRAMES(STEP_FRAMES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .presc_clr(start_ok),
        .max_value(max_value),
        .frame_end(frame_end),
        .step_tick(step_tick)
    );

    assign start_ok  = enable & start & (state_q == IDLE) & (level_min <= level_max);
    assign hold_done = (hold_q == hold_frames);
    assign step_eff  = (step == '0) ? bit_width'(1) : step;

    // The extra carry bit keeps level+step from wrapping before the ceiling clamp.
    assign rise_sum   = {1'b0, level_q} + {1'b0, step_eff};
    assign rise_level = (rise_sum > {1'b0, level_max}) ? level_max : rise_sum[bit_width-1:0];
    assign fall_gap   = level_q - level_min;
    assign fall_level = (fall_gap < step_eff) ? level_min : level_q - step_eff;

`ifdef DUTY_GAMMA_EN
    logic [2*bit_width-1:0] level_sq;
    assign level_sq  = {{bit_width{1'b0}}, level_q} * {{bit_width{1'b0}}, level_q};
    assign duty_next = level_sq[2*bit_width-1:bit_width];
`else
    assign duty_next = level_q;
`endif

    assign duty       = duty_q;
    assign busy       = (state_q != IDLE);
    assign cycle_done = frame_end & (state_q == HOLD_LO) & hold_done;

    // Duty latches the pre-update level at each frame_end, so it trails the level by one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            if (frame_end) begin
                duty_q <= duty_next;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        level_q <= level_min;
                        state_q <= RISE;
                    end
                end
                RISE: begin
                    if (step_tick) begin
                        level_q <= rise_level;
                        if (rise_level == level_max) begin
                            state_q <= HOLD_HI;
                            hold_q  <= '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (frame_end) begin
                        if (hold_done) begin
                            state_q <= FALL;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (step_tick) begin
                        level_q <= fall_level;
                        if (fall_level == level_min) begin
                            state_q <= HOLD_LO;
                            hold_q  <= '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (frame_end) begin
                        if (hold_done) begin
                            if (continuous) begin
                                state_q <= RISE;
                            end else begin
                                state_q <= IDLE;
                                level_q <= '0;
                            end
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
